// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer with CDB capture, operand query and rollback.
// Optional macro ROB_QRY_BYPASS_EN forwards a same-cycle CDB result to the operand query ports.
module reorder_buffer #(
  parameter int ROB_BIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               id_alloc_ena,
  input  logic [4:0]         id_alloc_rd,
  input  logic               id_alloc_br,
  input  logic               id_alloc_pred,
  input  logic [31:0]        id_alloc_pc,
  output logic [ROB_BIT-1:0] id_alloc_idx,
  output logic               rob_full,
  input  logic               cdb_ena,
  input  logic [ROB_BIT-1:0] cdb_idx,
  input  logic [31:0]        cdb_val,
  input  logic               cdb_taken,
  input  logic [31:0]        cdb_target,
  input  logic [ROB_BIT-1:0] id_qry1_idx,
  output logic               id_qry1_rdy,
  output logic [31:0]        id_qry1_val,
  input  logic [ROB_BIT-1:0] id_qry2_idx,
  output logic               id_qry2_rdy,
  output logic [31:0]        id_qry2_val,
  output logic               rob_wr_ena,
  output logic [4:0]         rob_wr_rd,
  output logic [31:0]        rob_wr_val,
  output logic [ROB_BIT-1:0] rob_wr_idx,
  output logic               rb_ena,
  output logic [31:0]        rb_pc
);

  localparam int DEPTH    = 1 << ROB_BIT;
  localparam int ROB_SIZE = DEPTH - 1;

  typedef logic [ROB_BIT-1:0] idx_t;

  // Slot 0 exists only so indices map directly; it is never allocated.
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] ready_q, ready_d;
  logic [DEPTH-1:0] br_q, br_d;
  logic [DEPTH-1:0] pred_q, pred_d;
  logic [DEPTH-1:0] taken_q, taken_d;
  logic [4:0]       rd_q     [DEPTH];
  logic [4:0]       rd_d     [DEPTH];
  logic [31:0]      pc_q     [DEPTH];
  logic [31:0]      pc_d     [DEPTH];
  logic [31:0]      val_q    [DEPTH];
  logic [31:0]      val_d    [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [31:0]      target_d [DEPTH];

  idx_t head_q, head_d;
  idx_t tail_q, tail_d;
  idx_t count_q, count_d;

  logic        wr_ena_q, wr_ena_d;
  logic [4:0]  wr_rd_q, wr_rd_d;
  logic [31:0] wr_val_q, wr_val_d;
  idx_t        wr_idx_q, wr_idx_d;
  logic        rb_ena_q, rb_ena_d;
  logic [31:0] rb_pc_q, rb_pc_d;

  logic full;
  logic alloc_go;
  logic commit_go;
  logic mispredict;

  function automatic idx_t next_idx(input idx_t i);
    return (i == idx_t'(ROB_SIZE)) ? idx_t'(1) : idx_t'(i + 1'b1);
  endfunction

  assign full = (count_q == idx_t'(ROB_SIZE));

  always_comb begin
    valid_d  = valid_q;
    ready_d  = ready_q;
    br_d     = br_q;
    pred_d   = pred_q;
    taken_d  = taken_q;
    rd_d     = rd_q;
    pc_d     = pc_q;
    val_d    = val_q;
    target_d = target_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    wr_ena_d = 1'b0;
    wr_rd_d  = wr_rd_q;
    wr_val_d = wr_val_q;
    wr_idx_d = wr_idx_q;
    rb_ena_d = 1'b0;
    rb_pc_d  = rb_pc_q;

    alloc_go   = rdy && id_alloc_ena && !full;
    commit_go  = rdy && valid_q[head_q] && ready_q[head_q];
    mispredict = commit_go && br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);

    // A stall holds any pending pulse so the consumer sees it once rdy returns.
    if (!rdy) begin
      wr_ena_d = wr_ena_q;
      rb_ena_d = rb_ena_q;
    end

    if (alloc_go) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = 1'b0;
      rd_d[tail_q]    = id_alloc_rd;
      br_d[tail_q]    = id_alloc_br;
      pred_d[tail_q]  = id_alloc_pred;
      pc_d[tail_q]    = id_alloc_pc;
      tail_d          = next_idx(tail_q);
    end

    if (rdy && cdb_ena && valid_q[cdb_idx]) begin
      ready_d[cdb_idx]  = 1'b1;
      val_d[cdb_idx]    = cdb_val;
      taken_d[cdb_idx]  = cdb_taken;
      target_d[cdb_idx] = cdb_target;
    end

    if (commit_go) begin
      valid_d[head_q] = 1'b0;
      ready_d[head_q] = 1'b0;
      val_d[head_q]   = '0;
      head_d          = next_idx(head_q);
      wr_ena_d        = (rd_q[head_q] != 5'd0);
      wr_rd_d         = rd_q[head_q];
      wr_val_d        = val_q[head_q];
      wr_idx_d        = head_q;
    end

    count_d = count_q + idx_t'(alloc_go) - idx_t'(commit_go);

    // Rollback overrides this cycle's allocation and CDB capture.
    if (mispredict) begin
      valid_d  = '0;
      ready_d  = '0;
      head_d   = idx_t'(1);
      tail_d   = idx_t'(1);
      count_d  = '0;
      rb_ena_d = 1'b1;
      rb_pc_d  = taken_q[head_q] ? target_q[head_q] : pc_q[head_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      ready_q <= '0;
      br_q    <= '0;
      pred_q  <= '0;
      taken_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]     <= '0;
        pc_q[i]     <= '0;
        val_q[i]    <= '0;
        target_q[i] <= '0;
      end
      head_q   <= idx_t'(1);
      tail_q   <= idx_t'(1);
      count_q  <= '0;
      wr_ena_q <= 1'b0;
      wr_rd_q  <= '0;
      wr_val_q <= '0;
      wr_idx_q <= '0;
      rb_ena_q <= 1'b0;
      rb_pc_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      br_q     <= br_d;
      pred_q   <= pred_d;
      taken_q  <= taken_d;
      rd_q     <= rd_d;
      pc_q     <= pc_d;
      val_q    <= val_d;
      target_q <= target_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wr_ena_q <= wr_ena_d;
      wr_rd_q  <= wr_rd_d;
      wr_val_q <= wr_val_d;
      wr_idx_q <= wr_idx_d;
      rb_ena_q <= rb_ena_d;
      rb_pc_q  <= rb_pc_d;
    end
  end

  always_comb begin
    id_qry1_rdy = 1'b0;
    id_qry1_val = val_q[id_qry1_idx];
    if (id_qry1_idx != '0 && valid_q[id_qry1_idx]) begin
      id_qry1_rdy = rdy && ready_q[id_qry1_idx];
`ifdef ROB_QRY_BYPASS_EN
      if (rdy && cdb_ena && cdb_idx == id_qry1_idx) begin
        id_qry1_rdy = 1'b1;
        id_qry1_val = cdb_val;
      end
`endif
    end
  end

  always_comb begin
    id_qry2_rdy = 1'b0;
    id_qry2_val = val_q[id_qry2_idx];
    if (id_qry2_idx != '0 && valid_q[id_qry2_idx]) begin
      id_qry2_rdy = rdy && ready_q[id_qry2_idx];
`ifdef ROB_QRY_BYPASS_EN
      if (rdy && cdb_ena && cdb_idx == id_qry2_idx) begin
        id_qry2_rdy = 1'b1;
        id_qry2_val = cdb_val;
      end
`endif
    end
  end

  assign id_alloc_idx = tail_q;
  assign rob_full     = full;
  assign rob_wr_ena   = wr_ena_q && rdy;
  assign rob_wr_rd    = wr_rd_q;
  assign rob_wr_val   = wr_val_q;
  assign rob_wr_idx   = wr_idx_q;
  assign rb_ena       = rb_ena_q && rdy;
  assign rb_pc        = rb_pc_q;

endmodule
